accumulator_writeback: RTL and testbench
========================================

// Module: accumulator_writeback
// PURPOSE
// Downstream of the systolic controller / 3x3 array. Deskews the three staggered column
// results (col k valid k cycles after col 0) into aligned rows. Writes or accumulates each
// row into a DEPTH-entry accumulator bank, and serves a registered read port to the output stage.
// PARAMETERS
// DATA_W  16  signed width of each array column output
// ACC_W   32  signed width of each accumulator lane (ACC_W > DATA_W)
// DEPTH   16  accumulator rows (power of 2); ADDR_W = $clog2(DEPTH)
// PORTS
// clk          in   1         clock
// rst_n        in   1         async active-low reset
// acc_wr_en    in   1         row r col0 result valid this cycle (held high for a contiguous burst)
// acc_wr_addr  in   8         base row address, sampled on first cycle of burst; low ADDR_W bits used
// acc_clear    in   1         single-cycle pulse: invalidate all rows, clear sat_flag
// acc_mode     in   1         0=overwrite, 1=accumulate; sampled with burst base address
// col0_in      in   DATA_W    array column 0 output (aligned with acc_wr_en)
// col1_in      in   DATA_W    array column 1 output (1 cycle after col0 of same row)
// col2_in      in   DATA_W    array column 2 output (2 cycles after col0 of same row)
// rd_en        in   1         read request
// rd_addr      in   ADDR_W    read row
// rd_data      out  3*ACC_W   {lane2,lane1,lane0}, valid with rd_valid
// rd_valid     out  1         read data valid
// wb_busy      out  1         burst or drain in progress
// wb_done      out  1         1-cycle pulse after last row of a burst is written
// sat_flag     out  1         sticky: any lane saturated since last clear/reset
// BEHAVIOUR
// - Reset: all outputs 0; all row valid bits 0; FSM IDLE; pointers and deskew regs 0.
//   Async reset mid-burst aborts the burst; no partial writes survive.
// - Deskew: col0 delayed 2 cycles, col1 delayed 1, col2 undelayed; a write-enable pipe
//   (acc_wr_en delayed 2) marks aligned rows. Write latency = 2 cycles from acc_wr_en.
// - Write pointer: loaded with acc_wr_addr[ADDR_W-1:0] on IDLE->STREAM.
//   Advances by 1 per aligned write and wraps modulo DEPTH.
// - FSM: IDLE --acc_wr_en--> STREAM (base/mode latched)
//   STREAM --!acc_wr_en--> DRAIN
//   DRAIN: 2 cycles flushing the deskew pipe, then -> DONE
//   DONE: wb_done=1 for one cycle, then -> IDLE
//   acc_wr_en re-asserted in DRAIN is a protocol error: ignored, row dropped.
// - wb_busy = state != IDLE.
// - Row write: per lane, old = valid ? mem : 0.
//   mode 0: mem = sext(in). mode 1: mem = sat(old + sext(in)).
//   The row valid bit is set on write.
// - Saturation: signed clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; sets sat_flag.
// - Clear: acc_clear zeroes all valid bits and sat_flag in 1 cycle, legal in any state.
//   If clear and a write land in the same cycle, clear applies first, then the write
//   (that row ends valid, computed from old = 0).
// - Read: rd_data and rd_valid are registered, 1-cycle latency; an invalid row reads as 0.
//   A read of the row written in the same cycle returns the pre-write value.
//   A read in the same cycle as clear returns the pre-clear value.
// TESTING
// 1 reset then rd_addr=0..15 -> rd_data=0 for all, rd_valid 1 cycle after each rd_en, sat_flag=0
// 2 burst of 3 rows, addr=4, mode 0, cols {1,2,3},{4,5,6},{7,8,9} with proper skew
//   -> rows 4..6 hold those values; first write 2 cycles after acc_wr_en; wb_done 3 cycles after burst ends
// 3 repeat scenario 2 with mode 1 -> rows 4..6 = {2,4,6},{8,10,12},{14,16,18}
// 4 burst of 3 at addr=15 -> writes rows 15,0,1 (wrap); row 14 untouched
// 5 mode 1, row preloaded 0x7FFFFFF0, add col0=0x7FFF -> lane0=0x7FFFFFFF, sat_flag=1;
//   acc_clear -> sat_flag=0 and row reads 0
// 6 acc_clear coincident with 2nd aligned write -> rows 0,2 read 0, row 1 holds new data;
//   rst_n low mid-burst -> busy=0, all rows read 0

Source files
------------

// File: rtl/accumulator_writeback.sv
// accumulator_writeback: deskews three staggered array columns into aligned rows, then writes or
// accumulates each row into a DEPTH-row bank that is read through a registered port.
module accumulator_writeback #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 acc_wr_en,
    input  logic [7:0]           acc_wr_addr,
    input  logic                 acc_clear,
    input  logic                 acc_mode,
    input  logic [DATA_W-1:0]    col0_in,
    input  logic [DATA_W-1:0]    col1_in,
    input  logic [DATA_W-1:0]    col2_in,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [3*ACC_W-1:0]   rd_data,
    output logic                 rd_valid,
    output logic                 wb_busy,
    output logic                 wb_done,
    output logic                 sat_flag
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state_q, state_d;
    logic                    drain_q, drain_d;
    logic [ADDR_W-1:0]       ptr_q, ptr_d;
    logic                    mode_q, mode_d;
    logic [1:0]              wr_pipe_q, wr_pipe_d;
    logic [1:0][DATA_W-1:0]  c0_q, c0_d;
    logic [DATA_W-1:0]       c1_q, c1_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic                    sat_q, sat_d;
    logic [3*ACC_W-1:0]      rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [3*ACC_W-1:0]      mem_q [DEPTH];
    logic [2:0][DATA_W-1:0]  lane_in;
    logic [3*ACC_W-1:0]      old_row, row_d;
    logic [ACC_W:0]          sum [3];
    logic [2:0]              ovf;
    logic                    wr;
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^acc_wr_addr[7:ADDR_W];
    assign wr             = wr_pipe_q[1];
    assign lane_in        = {col2_in, c1_q, c0_q[1]};
    // A clear landing with a write wins first, so the written row starts from zero
    assign old_row        = (valid_q[ptr_q] && !acc_clear) ? mem_q[ptr_q] : '0;

    always_comb begin
        row_d = '0;
        ovf   = '0;
        for (int l = 0; l < 3; l++) begin
            sum[l] = {old_row[l*ACC_W+ACC_W-1], old_row[l*ACC_W +: ACC_W]}
                   + {{(ACC_W+1-DATA_W){lane_in[l][DATA_W-1]}}, lane_in[l]};
            ovf[l] = mode_q && (sum[l][ACC_W] != sum[l][ACC_W-1]);
            row_d[l*ACC_W +: ACC_W] = !mode_q ? {{(ACC_W-DATA_W){lane_in[l][DATA_W-1]}}, lane_in[l]}
                                    : ovf[l] ? (sum[l][ACC_W] ? ACC_MIN : ACC_MAX)
                                    : sum[l][ACC_W-1:0];
        end
    end

    always_comb begin
        state_d    = state_q == IDLE   ? (acc_wr_en ? STREAM : IDLE)
                   : state_q == STREAM ? (acc_wr_en ? STREAM : DRAIN)
                   : state_q == DRAIN  ? (drain_q ? DONE : DRAIN)
                   : IDLE;
        drain_d    = state_q == DRAIN && !drain_q;
        ptr_d      = (state_q == IDLE && acc_wr_en) ? acc_wr_addr[ADDR_W-1:0]
                   : wr ? ptr_q + ADDR_W'(1) : ptr_q;
        mode_d     = (state_q == IDLE && acc_wr_en) ? acc_mode : mode_q;
        // Rows offered while draining or finishing are protocol errors and are dropped here
        wr_pipe_d  = {wr_pipe_q[0], acc_wr_en && (state_q == IDLE || state_q == STREAM)};
        c0_d       = {c0_q[0], col0_in};
        c1_d       = col1_in;
        valid_d    = acc_clear ? '0 : valid_q;
        if (wr) valid_d[ptr_q] = 1'b1;
        sat_d      = (sat_q && !acc_clear) || (wr && |ovf);
        rd_valid_d = rd_en;
        rd_data_d  = !rd_en ? rd_data_q : valid_q[rd_addr] ? mem_q[rd_addr] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            drain_q    <= 1'b0;
            ptr_q      <= '0;
            mode_q     <= 1'b0;
            wr_pipe_q  <= '0;
            c0_q       <= '0;
            c1_q       <= '0;
            valid_q    <= '0;
            sat_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            ptr_q      <= ptr_d;
            mode_q     <= mode_d;
            wr_pipe_q  <= wr_pipe_d;
            c0_q       <= c0_d;
            c1_q       <= c1_d;
            valid_q    <= valid_d;
            sat_q      <= sat_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Row storage carries no reset; the valid bits decide what a row reads as
    always_ff @(posedge clk) begin
        if (wr) mem_q[ptr_q] <= row_d;
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign wb_busy  = state_q != IDLE;
    assign wb_done  = state_q == DONE;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_accumulator_writeback.sv
// tb_accumulator_writeback: random and directed bursts checked against an arithmetic bank model.
// A 20-bit accumulator keeps the saturation limits reachable within a short run.
module tb_accumulator_writeback;
    localparam int DW = 16;
    localparam int AW = 20;
    localparam int DEPTH = 16;
    localparam longint MAXV = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (AW - 1));

    logic clk = 0, rst_n = 0;
    logic acc_wr_en = 0, acc_clear = 0, acc_mode = 0, rd_en = 0;
    logic [7:0] acc_wr_addr = '0;
    logic [DW-1:0] col0_in = '0, col1_in = '0, col2_in = '0;
    logic [3:0] rd_addr = '0;
    logic [3*AW-1:0] rd_data;
    logic rd_valid, wb_busy, wb_done, sat_flag;

    int total = 0, bad = 0;
    longint m_mem [DEPTH][3];
    bit m_valid [DEPTH];
    bit m_sat, rd_pend;
    logic [95:0] rd_exp;
    logic signed [DW-1:0] rows [512][3];

    accumulator_writeback #(.DATA_W(DW), .ACC_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr),
        .acc_clear(acc_clear), .acc_mode(acc_mode), .col0_in(col0_in), .col1_in(col1_in),
        .col2_in(col2_in), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .wb_busy(wb_busy), .wb_done(wb_done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] row_of(input int a);
        logic [95:0] e = '0;
        longint x;
        if (m_valid[a])
            for (int l = 0; l < 3; l++) begin
                x = m_mem[a][l];
                e[l*AW +: AW] = x[AW-1:0];
            end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        m_sat = 0;
        rd_pend = 0;
    endtask

    // Checks what the previous cycle produced, then drives idle defaults for the new cycle
    task automatic next_cycle();
        @(negedge clk);
        chk("rd_valid", rd_valid, rd_pend);
        if (rd_pend) chk("rd_data", rd_data, rd_exp);
        chk("sat_flag", sat_flag, m_sat);
        rd_pend = 0;
        acc_wr_en = 0;
        acc_clear = 0;
        rd_en = 0;
        acc_wr_addr = 8'($urandom);
        acc_mode = 1'($urandom);
        col0_in = 16'($urandom);
        col1_in = 16'($urandom);
        col2_in = 16'($urandom);
        rd_addr = 4'($urandom);
    endtask

    // Read sees the bank before this cycle's clear and write; clear precedes write
    task automatic model_cycle();
        if (rd_en) begin
            rd_exp = row_of(int'(rd_addr));
            rd_pend = 1;
        end
        if (acc_clear) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
            m_sat = 0;
        end
    endtask

    task automatic model_write(input int a, input int j, input bit md);
        longint s, old;
        for (int l = 0; l < 3; l++) begin
            old = m_valid[a] ? m_mem[a][l] : 0;
            s = md ? old + longint'(rows[j][l]) : longint'(rows[j][l]);
            if (s > MAXV) begin s = MAXV; m_sat = 1; end
            else if (s < MINV) begin s = MINV; m_sat = 1; end
            m_mem[a][l] = s;
        end
        m_valid[a] = 1;
    endtask

    task automatic fill_random(input int n);
        for (int j = 0; j < n; j++)
            for (int l = 0; l < 3; l++) rows[j][l] = 16'($urandom);
    endtask

    task automatic burst(input int n, input int base, input bit md, input int clr_at);
        int done_at = -1, ndone = 0;
        for (int t = 0; t < n + 5; t++) begin
            next_cycle();
            if (wb_done) begin
                ndone++;
                if (done_at < 0) done_at = t;
            end
            if (t == 1) chk("busy_stream", wb_busy, 1);
            if (t == n + 4) chk("busy_idle", wb_busy, 0);
            if (t == 0) begin
                acc_wr_addr = 8'(base);
                acc_mode = md;
            end
            acc_wr_en = t < n;
            if (t < n) col0_in = rows[t][0];
            if (t >= 1 && t <= n) col1_in = rows[t-1][1];
            if (t >= 2 && t <= n + 1) col2_in = rows[t-2][2];
            acc_clear = t == clr_at;
            if (t == 2 || t == 3) begin
                rd_en = 1;
                rd_addr = 4'(base);
            end
            model_cycle();
            if (t >= 2 && t <= n + 1) model_write((base + t - 2) & (DEPTH - 1), t - 2, md);
        end
        chk("done_cycle", done_at, n + 3);
        chk("done_count", ndone, 1);
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) begin
            next_cycle();
            rd_en = 1;
            rd_addr = 4'(a);
            model_cycle();
        end
        next_cycle();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", wb_busy, 0);
        chk("rst_done", wb_done, 0);
        chk("rst_sat", sat_flag, 0);
        rst_n = 1;
        read_all();

        for (int j = 0; j < 3; j++)
            for (int l = 0; l < 3; l++) rows[j][l] = 16'(3 * j + l + 1);
        burst(3, 4, 0, -1);
        read_all();
        burst(3, 4, 1, -1);
        read_all();

        fill_random(1);
        burst(1, 14, 0, -1);
        fill_random(3);
        burst(3, 255, 1, -1);
        read_all();

        fill_random(3);
        burst(3, 0, 0, -1);
        fill_random(2);
        burst(2, 0, 1, 3);
        read_all();

        repeat (12) begin
            fill_random(8);
            burst($urandom_range(1, 6), $urandom_range(0, 255), 1'($urandom),
                  $urandom_range(0, 5) == 0 ? $urandom_range(0, 8) : -1);
            repeat ($urandom_range(0, 3)) begin
                next_cycle();
                rd_en = 1'($urandom);
                acc_clear = $urandom_range(0, 7) == 0;
                model_cycle();
            end
        end
        read_all();

        next_cycle();
        acc_clear = 1;
        model_cycle();
        for (int j = 0; j < 257; j++) begin
            rows[j][0] = 16'h7FFF;
            rows[j][1] = 16'h8000;
            rows[j][2] = 16'(j);
        end
        burst(257, 3, 1, -1);
        next_cycle();
        rd_en = 1;
        rd_addr = 4'd3;
        model_cycle();
        next_cycle();
        chk("sat_row3", rd_data, {20'd2176, 20'h80000, 20'h7FFFF});
        chk("sat_after_overflow", sat_flag, 1);
        read_all();
        next_cycle();
        acc_clear = 1;
        rd_en = 1;
        rd_addr = 4'd3;
        model_cycle();
        next_cycle();
        chk("sat_cleared", sat_flag, 0);
        read_all();

        fill_random(8);
        for (int t = 0; t < 4; t++) begin
            next_cycle();
            acc_wr_en = 1;
            if (t == 0) begin
                acc_wr_addr = 8'd5;
                acc_mode = 0;
            end
            col0_in = rows[t][0];
            model_cycle();
        end
        #2 rst_n = 0;
        #1;
        chk("midrst_busy", wb_busy, 0);
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_done", wb_done, 0);
        model_reset();
        acc_wr_en = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        read_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
